// File: rtl/interrupt_controller_if.sv
// Bus between the interrupt controller and its host (Program_Counter / CSR side).
// master = host side driving requests and handshakes, slave = the controller.
interface interrupt_controller_if;
  logic [3:0] irq;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic       int_ack;
  logic       rti;
  logic       interrupt_signal;
  logic [7:0] interrupt_vector_addr;
  logic [1:0] active_id;
  logic [3:0] pending;
  logic [3:0] mask;
  logic       busy;

  modport master (
    output irq, mask_we, mask_wdata, int_ack, rti,
    input  interrupt_signal, interrupt_vector_addr, active_id, pending, mask, busy
  );

  modport slave (
    input  irq, mask_we, mask_wdata, int_ack, rti,
    output interrupt_signal, interrupt_vector_addr, active_id, pending, mask, busy
  );
endinterface

// File: rtl/interrupt_controller.sv
// 4-source fixed-priority interrupt controller (IDLE/REQUEST/SERVICE, no nesting).
// Define INTC_EDGE_DETECT_EN for edge-latched pending bits; default is level-sensitive.
module interrupt_controller #(
  parameter logic [7:0] VECTOR_BASE   = 8'hF0,
  parameter logic [7:0] VECTOR_STRIDE = 8'd4
) (
  input logic             clk,
  input logic             reset,
  interrupt_controller_if.slave bus
);

  typedef enum logic [1:0] {IDLE, REQUEST, SERVICE} state_t;

  state_t     state_q;
  logic [3:0] irq_q;
  logic [3:0] pending_q, pending_d;
  logic [3:0] mask_q, mask_d;
  logic [3:0] eligible;
  logic [1:0] sel_id;
  logic [7:0] sel_vector;
  logic [1:0] active_id_q;
  logic [7:0] vector_q;
  logic       interrupt_signal_q;
  logic       busy_q;

`ifdef INTC_EDGE_DETECT_EN
  logic [3:0] irq_prev_q;
  logic [3:0] ack_clr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) irq_prev_q <= 4'b0000;
    else        irq_prev_q <= irq_q;
  end
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq_q     <= 4'b0000;
      pending_q <= 4'b0000;
      mask_q    <= 4'b0000;
    end else begin
      irq_q     <= bus.irq;
      pending_q <= pending_d;
      mask_q    <= mask_d;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (bus.mask_we) mask_d = bus.mask_wdata;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_pending
`ifdef INTC_EDGE_DETECT_EN
    // A new rising edge in the acknowledge cycle keeps the bit set.
    assign ack_clr[gi]   = (state_q == REQUEST) && bus.int_ack && (active_id_q == 2'(gi));
    assign pending_d[gi] = (irq_q[gi] & ~irq_prev_q[gi]) | (pending_q[gi] & ~ack_clr[gi]);
`else
    assign pending_d[gi] = irq_q[gi];
`endif
  end

  assign eligible = pending_q & mask_q;

  // Lowest index wins: scan from the top so the last hit is the lowest bit.
  always_comb begin
    sel_id = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (eligible[i]) sel_id = 2'(i);
    end
    sel_vector = VECTOR_BASE + (8'(sel_id) * VECTOR_STRIDE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q            <= IDLE;
      active_id_q        <= 2'd0;
      vector_q           <= VECTOR_BASE;
      interrupt_signal_q <= 1'b0;
      busy_q             <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (|eligible) begin
            state_q            <= REQUEST;
            active_id_q        <= sel_id;
            vector_q           <= sel_vector;
            interrupt_signal_q <= 1'b1;
            busy_q             <= 1'b1;
          end
        end
        REQUEST: begin
          if (bus.int_ack) begin
            state_q            <= SERVICE;
            interrupt_signal_q <= 1'b0;
          end
        end
        SERVICE: begin
          // Returning to IDLE here guarantees one IDLE cycle before re-arbitration.
          if (bus.rti) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q            <= IDLE;
          interrupt_signal_q <= 1'b0;
          busy_q             <= 1'b0;
        end
      endcase
    end
  end

  assign bus.interrupt_signal      = interrupt_signal_q;
  assign bus.interrupt_vector_addr = vector_q;
  assign bus.active_id             = active_id_q;
  assign bus.pending               = pending_q;
  assign bus.mask                  = mask_q;
  assign bus.busy                  = busy_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Self-checking bench: directed vector table, reset/wrap sequences, then random
// traffic against a cycle-level reference model of the controller's rules.
`timescale 1ns/1ps
module tb_interrupt_controller;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  interrupt_controller_if bus ();
  interrupt_controller_if bus2 ();

  interrupt_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  interrupt_controller #(
    .VECTOR_BASE   (8'hFC),
    .VECTOR_STRIDE (8'd4)
  ) dut_wrap (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  int total  = 0;
  int passed = 0;

  typedef struct {
    logic [3:0] irq;
    logic       we;
    logic [3:0] wd;
    logic       ack;
    logic       rti;
    logic       sig;
    logic       busy;
    logic [1:0] id;
    logic [7:0] vec;
    logic [3:0] pend_edge;
    logic [3:0] pend_level;
    logic [3:0] mask;
  } vec_t;

  vec_t tbl[$];

  // Reference model state
  bit         model_on = 0;
  logic [3:0] m_seen, m_prev, m_pend, m_mask;
  logic [1:0] m_id;
  bit         m_req, m_srv;
  int         served = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic add(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                     input logic ack, input logic rti, input logic sig, input logic bsy,
                     input logic [1:0] id, input logic [7:0] vec, input logic [3:0] pe,
                     input logic [3:0] pl, input logic [3:0] msk);
    vec_t v;
    v = '{irq, we, wd, ack, rti, sig, bsy, id, vec, pe, pl, msk};
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                       input logic ack, input logic rti);
    bus.irq        = irq;
    bus.mask_we    = we;
    bus.mask_wdata = wd;
    bus.int_ack    = ack;
    bus.rti        = rti;
  endtask

  task automatic model_reset();
    m_seen = '0; m_prev = '0; m_pend = '0; m_mask = '0;
    m_id = 2'd0; m_req = 0; m_srv = 0;
  endtask

  // One clock of the controller's rules, applied to the inputs seen at the edge.
  task automatic model_edge(input logic [3:0] irq, input logic we, input logic [3:0] wd,
                            input logic ack, input logic rti);
    logic [3:0] p;
    logic [3:0] cand;
`ifdef INTC_EDGE_DETECT_EN
    p = m_pend;
    if (m_req && ack) p[m_id] = 1'b0;
    p = p | (m_seen & ~m_prev);
`else
    p = m_seen;
`endif
    cand = m_pend & m_mask;
    if (!m_req && !m_srv) begin
      if (cand != 4'b0000) begin
        for (int i = 0; i < 4; i++) begin
          if (cand[i]) begin
            m_id = 2'(i);
            break;
          end
        end
        m_req = 1;
      end
    end else if (m_req) begin
      if (ack) begin
        m_req = 0;
        m_srv = 1;
        served++;
        $display("random: source %0d acknowledged (serviced so far %0d)", m_id, served);
      end
    end else if (rti) begin
      m_srv = 0;
    end
    m_pend = p;
    m_prev = m_seen;
    m_seen = irq;
    if (we) m_mask = wd;
  endtask

  task automatic step();
    logic [3:0] irq, wd;
    logic we, ack, rti;
    irq = bus.irq; we = bus.mask_we; wd = bus.mask_wdata; ack = bus.int_ack; rti = bus.rti;
    @(posedge clk);
    if (model_on) model_edge(irq, we, wd, ack, rti);
    #1;
  endtask

  task automatic check_model();
    int vexp;
    vexp = (240 + int'(m_id) * 4) % 256;
    chk("rnd_sig",  bus.interrupt_signal, m_req);
    chk("rnd_busy", bus.busy, m_req | m_srv);
    chk("rnd_id",   bus.active_id, m_id);
    chk("rnd_vec",  bus.interrupt_vector_addr, vexp[7:0]);
    chk("rnd_pend", bus.pending, m_pend);
    chk("rnd_mask", bus.mask, m_mask);
  endtask

  initial begin
    logic [3:0] pexp;
    drive(4'h0, 0, 4'h0, 0, 0);
    bus2.irq = 4'b1000; bus2.mask_we = 1'b1; bus2.mask_wdata = 4'hF;
    bus2.int_ack = 1'b0; bus2.rti = 1'b0;

    // Reset values while reset is held
    #12;
    chk("rst_sig",  bus.interrupt_signal, 1'b0);
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_pend", bus.pending, 4'h0);
    chk("rst_mask", bus.mask, 4'h0);
    chk("rst_id",   bus.active_id, 2'd0);
    chk("rst_vec",  bus.interrupt_vector_addr, 8'hF0);
    @(negedge clk);
    reset = 1'b1;

    //   irq  we wd  ak rt  sig bsy id vec    pe    pl    mask
    add(4'h0, 1, 4'hF, 0, 0, 0, 0, 0, 8'hF0, 4'h0, 4'h0, 4'hF);
    add(4'h4, 0, 4'h0, 0, 0, 0, 0, 0, 8'hF0, 4'h0, 4'h0, 4'hF);
    add(4'h0, 0, 4'h0, 0, 0, 0, 0, 0, 8'hF0, 4'h4, 4'h4, 4'hF);
    add(4'h0, 0, 4'h0, 0, 0, 1, 1, 2, 8'hF8, 4'h4, 4'h0, 4'hF);
    add(4'h0, 0, 4'h0, 1, 0, 0, 1, 2, 8'hF8, 4'h0, 4'h0, 4'hF);
    add(4'h0, 0, 4'h0, 0, 1, 0, 0, 2, 8'hF8, 4'h0, 4'h0, 4'hF);
    add(4'hA, 0, 4'h0, 0, 0, 0, 0, 2, 8'hF8, 4'h0, 4'h0, 4'hF);
    add(4'h8, 0, 4'h0, 0, 0, 0, 0, 2, 8'hF8, 4'hA, 4'hA, 4'hF);
    add(4'h8, 0, 4'h0, 0, 0, 1, 1, 1, 8'hF4, 4'hA, 4'h8, 4'hF);
    add(4'h8, 0, 4'h0, 1, 0, 0, 1, 1, 8'hF4, 4'h8, 4'h8, 4'hF);
    add(4'h8, 0, 4'h0, 0, 1, 0, 0, 1, 8'hF4, 4'h8, 4'h8, 4'hF);
    add(4'h0, 0, 4'h0, 0, 0, 1, 1, 3, 8'hFC, 4'h8, 4'h8, 4'hF);
    add(4'h0, 0, 4'h0, 1, 0, 0, 1, 3, 8'hFC, 4'h0, 4'h0, 4'hF);
    add(4'h0, 0, 4'h0, 0, 1, 0, 0, 3, 8'hFC, 4'h0, 4'h0, 4'hF);
    add(4'h0, 1, 4'hE, 0, 0, 0, 0, 3, 8'hFC, 4'h0, 4'h0, 4'hE);
    add(4'h1, 0, 4'h0, 0, 0, 0, 0, 3, 8'hFC, 4'h0, 4'h0, 4'hE);
    add(4'h1, 0, 4'h0, 0, 0, 0, 0, 3, 8'hFC, 4'h1, 4'h1, 4'hE);
    add(4'h1, 0, 4'h0, 0, 0, 0, 0, 3, 8'hFC, 4'h1, 4'h1, 4'hE);
    add(4'h1, 1, 4'hF, 0, 0, 0, 0, 3, 8'hFC, 4'h1, 4'h1, 4'hF);
    add(4'h1, 0, 4'h0, 0, 0, 1, 1, 0, 8'hF0, 4'h1, 4'h1, 4'hF);
    add(4'h0, 1, 4'h0, 0, 0, 1, 1, 0, 8'hF0, 4'h1, 4'h1, 4'h0);
    add(4'h0, 0, 4'h0, 1, 0, 0, 1, 0, 8'hF0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 0, 4'h0, 0, 1, 0, 0, 0, 8'hF0, 4'h0, 4'h0, 4'h0);
    add(4'h0, 0, 4'h0, 1, 1, 0, 0, 0, 8'hF0, 4'h0, 4'h0, 4'h0);
    add(4'h4, 1, 4'hF, 0, 0, 0, 0, 0, 8'hF0, 4'h0, 4'h0, 4'hF);
    add(4'h4, 0, 4'h0, 0, 0, 0, 0, 0, 8'hF0, 4'h4, 4'h4, 4'hF);
    add(4'h4, 0, 4'h0, 0, 0, 1, 1, 2, 8'hF8, 4'h4, 4'h4, 4'hF);
    add(4'h0, 0, 4'h0, 1, 0, 0, 1, 2, 8'hF8, 4'h0, 4'h4, 4'hF);
    add(4'h1, 0, 4'h0, 0, 0, 0, 1, 2, 8'hF8, 4'h0, 4'h0, 4'hF);
    add(4'h1, 0, 4'h0, 0, 0, 0, 1, 2, 8'hF8, 4'h1, 4'h1, 4'hF);
    add(4'h1, 0, 4'h0, 0, 0, 0, 1, 2, 8'hF8, 4'h1, 4'h1, 4'hF);
    add(4'h1, 0, 4'h0, 0, 1, 0, 0, 2, 8'hF8, 4'h1, 4'h1, 4'hF);
    add(4'h0, 0, 4'h0, 0, 0, 1, 1, 0, 8'hF0, 4'h1, 4'h1, 4'hF);
    add(4'h0, 0, 4'h0, 1, 0, 0, 1, 0, 8'hF0, 4'h0, 4'h0, 4'hF);
    add(4'h0, 0, 4'h0, 0, 1, 0, 0, 0, 8'hF0, 4'h0, 4'h0, 4'hF);

    foreach (tbl[k]) begin
      drive(tbl[k].irq, tbl[k].we, tbl[k].wd, tbl[k].ack, tbl[k].rti);
      step();
`ifdef INTC_EDGE_DETECT_EN
      pexp = tbl[k].pend_edge;
`else
      pexp = tbl[k].pend_level;
`endif
      $display("row %0d: irq=%h ack=%0d rti=%0d -> sig=%0d busy=%0d id=%0d vec=%h pend=%h mask=%h",
               k, tbl[k].irq, tbl[k].ack, tbl[k].rti, bus.interrupt_signal, bus.busy,
               bus.active_id, bus.interrupt_vector_addr, bus.pending, bus.mask);
      chk($sformatf("row%0d_sig", k),  bus.interrupt_signal, tbl[k].sig);
      chk($sformatf("row%0d_busy", k), bus.busy, tbl[k].busy);
      chk($sformatf("row%0d_id", k),   bus.active_id, tbl[k].id);
      chk($sformatf("row%0d_vec", k),  bus.interrupt_vector_addr, tbl[k].vec);
      chk($sformatf("row%0d_pend", k), bus.pending, pexp);
      chk($sformatf("row%0d_mask", k), bus.mask, tbl[k].mask);
    end

    // Wrapped vector on the second instance: 0xFC + 3*4 = 0x108 -> 0x08
    $display("wrap: sig=%0d id=%0d vec=%h", bus2.interrupt_signal, bus2.active_id,
             bus2.interrupt_vector_addr);
    chk("wrap_sig", bus2.interrupt_signal, 1'b1);
    chk("wrap_id",  bus2.active_id, 2'd3);
    chk("wrap_vec", bus2.interrupt_vector_addr, 8'h08);

    // Reset asserted mid-REQUEST aborts everything immediately
    drive(4'h2, 0, 4'h0, 0, 0); step();
    drive(4'h0, 0, 4'h0, 0, 0); step();
    step();
    chk("pre_rst_sig", bus.interrupt_signal, 1'b1);
    chk("pre_rst_id",  bus.active_id, 2'd1);
    #3;
    reset = 1'b0;
    #1;
    $display("async reset: sig=%0d busy=%0d pend=%h mask=%h", bus.interrupt_signal, bus.busy,
             bus.pending, bus.mask);
    chk("arst_sig",  bus.interrupt_signal, 1'b0);
    chk("arst_busy", bus.busy, 1'b0);
    chk("arst_pend", bus.pending, 4'h0);
    chk("arst_mask", bus.mask, 4'h0);
    chk("arst_vec",  bus.interrupt_vector_addr, 8'hF0);
    @(negedge clk);
    reset = 1'b1;
    drive(4'h0, 1, 4'hF, 0, 0); step();
    drive(4'h0, 0, 4'h0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      chk("post_rst_quiet", bus.interrupt_signal, 1'b0);
      chk("post_rst_pend", bus.pending, 4'h0);
    end

    // Random traffic checked against the reference model
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    model_on = 1;
    for (int c = 0; c < 3000; c++) begin
      drive(4'($urandom) & 4'($urandom) & 4'($urandom),
            ($urandom_range(0, 7) == 0), 4'($urandom),
            1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0));
      step();
      check_model();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
